// File: rtl/joy_pkg.sv
// joy_pkg: shared direction/state types and 25 MHz timing defaults for the joystick conditioner
package joy_pkg;
    typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} joy_dir_t;
    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} joy_state_t;
    localparam int DEF_DEBOUNCE_CYC     = 250000;
    localparam int DEF_REPEAT_DELAY_CYC = 6250000;
    localparam int DEF_REPEAT_RATE_CYC  = 2500000;
    localparam int DEF_START_HOLD_CYC   = 25000000;
    function automatic int cw(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/joy_debounce.sv
// joy_debounce: 2-flop synchroniser, polarity normalisation and stable-count debounce for one raw line
module joy_debounce
    import joy_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);
    localparam int W = cw(DEBOUNCE_CYC);
    localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYC - 1);
    logic [1:0] sync;
    logic [W-1:0] cnt;
    logic pressed;
    logic differ;
    assign pressed = sync[1] ^ ACTIVE_LOW;
    assign differ = pressed != level;
    // Synchroniser resets to the released level so reset release never looks like a press.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sync <= {2{ACTIVE_LOW}};
            cnt <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            cnt <= (!differ || cnt == LAST) ? '0 : cnt + 1'b1;
            level <= (differ && cnt == LAST) ? ~level : level;
        end
endmodule

// File: rtl/joy_conditioner.sv
// joy_conditioner: debounced arcade-stick lines to move pulses with auto-repeat, fire/start pulses and LEDs
module joy_conditioner
    import joy_pkg::*;
#(
    parameter int DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
    parameter int REPEAT_RATE_CYC  = DEF_REPEAT_RATE_CYC,
    parameter int START_HOLD_CYC   = DEF_START_HOLD_CYC,
    parameter bit ACTIVE_LOW       = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_left,
    input  logic       i_right,
    input  logic       i_fire,
    output logic       o_up,
    output logic       o_down,
    output logic       o_left,
    output logic       o_right,
    output logic       o_fire,
    output logic       o_start,
    output logic [4:0] o_led
);
    localparam int TW = cw(REPEAT_DELAY_CYC > REPEAT_RATE_CYC ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC);
    localparam int HW = cw(START_HOLD_CYC);
    localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY_CYC - 1);
    localparam logic [TW-1:0] RATE_LAST  = TW'(REPEAT_RATE_CYC - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(START_HOLD_CYC - 1);
    logic [4:0] raw;
    logic [4:0] lvl;
    joy_dir_t dir, cur, cur_n, mv;
    joy_state_t state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic pulse;
    logic fire_d;
    logic [HW-1:0] hold;
    logic start_done;
    assign raw = {i_fire, i_right, i_left, i_down, i_up};
    for (genvar g = 0; g < 5; g++) begin : g_line
        joy_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .ACTIVE_LOW(ACTIVE_LOW)
        ) u_db (
            .clk(clk),
            .rst(rst),
            .raw(raw[g]),
            .level(lvl[g])
        );
    end
    assign dir = lvl[0] ? DIR_UP : lvl[1] ? DIR_DOWN : lvl[2] ? DIR_LEFT : lvl[3] ? DIR_RIGHT : DIR_NONE;
    // A new direction (from IDLE or a change while held) always restarts the delay phase.
    always_comb begin
        state_n = state;
        cur_n = cur;
        timer_n = timer;
        pulse = 1'b0;
        if (dir == DIR_NONE) begin
            state_n = ST_IDLE;
            timer_n = '0;
        end else if (state == ST_IDLE || dir != cur) begin
            pulse = 1'b1;
            state_n = ST_DELAY;
            cur_n = dir;
            timer_n = '0;
        end else if (timer == (state == ST_DELAY ? DELAY_LAST : RATE_LAST)) begin
            pulse = 1'b1;
            state_n = ST_REPEAT;
            timer_n = '0;
        end else begin
            timer_n = timer + 1'b1;
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= ST_IDLE;
            cur <= DIR_NONE;
            timer <= '0;
            mv <= DIR_NONE;
        end else begin
            state <= state_n;
            cur <= cur_n;
            timer <= timer_n;
            mv <= pulse ? dir : DIR_NONE;
        end
    // Hold counter saturates; start_done blocks a second start until fire is released.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            fire_d <= 1'b0;
            o_fire <= 1'b0;
            hold <= '0;
            start_done <= 1'b0;
            o_start <= 1'b0;
            o_led <= '0;
        end else begin
            fire_d <= lvl[4];
            o_fire <= lvl[4] & ~fire_d;
            hold <= !lvl[4] ? '0 : hold == HOLD_LAST ? hold : hold + 1'b1;
            start_done <= lvl[4] && (start_done || hold == HOLD_LAST);
            o_start <= lvl[4] && hold == HOLD_LAST && !start_done;
            o_led <= lvl;
        end
    assign o_up = mv == DIR_UP;
    assign o_down = mv == DIR_DOWN;
    assign o_left = mv == DIR_LEFT;
    assign o_right = mv == DIR_RIGHT;
endmodule

// File: tb/tb_joy_conditioner.sv
// tb_joy_conditioner: directed and random stimulus against a cycle-level behavioural model of the conditioner
module tb_joy_conditioner;
    import joy_pkg::*;
    localparam int DB = 4, RD = 20, RR = 8, SH = 50;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_up = 1'b1, i_down = 1'b1, i_left = 1'b1, i_right = 1'b1, i_fire = 1'b1;
    logic o_up, o_down, o_left, o_right, o_fire, o_start;
    logic [4:0] o_led;
    logic p_up = 1'b0, p_down = 1'b0, p_left = 1'b0, p_right = 1'b0, p_fire = 1'b0;
    logic q_up, q_down, q_left, q_right, q_fire, q_start;
    logic [4:0] q_led;
    int tests = 0, fails = 0;
    logic [4:0] m_q0, m_q1, m_lvl, e_led;
    int m_run [5];
    int m_cyc, m_t0, m_hold;
    bit m_active, m_rose, e_fire, e_start;
    joy_dir_t m_cur, e_mv;
    int k, k0, n_fire, n_start, n_up, n_down, n_right, fire_at, start_at, up_at, down_at, right_at;

    always #5 clk = ~clk;

    joy_conditioner #(.DEBOUNCE_CYC(DB), .REPEAT_DELAY_CYC(RD), .REPEAT_RATE_CYC(RR),
                      .START_HOLD_CYC(SH), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .i_up(i_up), .i_down(i_down), .i_left(i_left), .i_right(i_right),
        .i_fire(i_fire), .o_up(o_up), .o_down(o_down), .o_left(o_left), .o_right(o_right),
        .o_fire(o_fire), .o_start(o_start), .o_led(o_led));

    joy_conditioner #(.DEBOUNCE_CYC(DB), .REPEAT_DELAY_CYC(RD), .REPEAT_RATE_CYC(RR),
                      .START_HOLD_CYC(SH), .ACTIVE_LOW(1'b0)) dut_p (
        .clk(clk), .rst(rst), .i_up(p_up), .i_down(p_down), .i_left(p_left), .i_right(p_right),
        .i_fire(p_fire), .o_up(q_up), .o_down(q_down), .o_left(q_left), .o_right(q_right),
        .o_fire(q_fire), .o_start(q_start), .o_led(q_led));

    task automatic chk(input string tag, input int got, input int want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    function automatic int mv_bits(input joy_dir_t d);
        return d == DIR_UP ? 1 : d == DIR_DOWN ? 2 : d == DIR_LEFT ? 4 : d == DIR_RIGHT ? 8 : 0;
    endfunction

    task automatic model_reset();
        m_q0 = '1;
        m_q1 = '1;
        m_lvl = '0;
        for (int i = 0; i < 5; i++) m_run[i] = 0;
        m_cyc = 0;
        m_t0 = 0;
        m_hold = 0;
        m_active = 0;
        m_rose = 0;
        m_cur = DIR_NONE;
        e_led = '0;
        e_fire = 0;
        e_start = 0;
        e_mv = DIR_NONE;
    endtask

    // Outputs after an edge follow from the model state before it; then the model state advances.
    task automatic model_edge();
        joy_dir_t d;
        int el;
        m_cyc++;
        e_led = m_lvl;
        e_fire = m_rose;
        m_hold = m_lvl[4] ? m_hold + 1 : 0;
        e_start = m_hold == SH;
        d = m_lvl[0] ? DIR_UP : m_lvl[1] ? DIR_DOWN : m_lvl[2] ? DIR_LEFT : m_lvl[3] ? DIR_RIGHT : DIR_NONE;
        e_mv = DIR_NONE;
        el = m_cyc - m_t0;
        if (d == DIR_NONE) m_active = 0;
        else if (!m_active || d != m_cur) begin
            m_active = 1;
            m_cur = d;
            m_t0 = m_cyc;
            e_mv = d;
        end else if (el == RD || (el > RD && (el - RD) % RR == 0)) e_mv = d;
        m_rose = 0;
        for (int i = 0; i < 5; i++) begin
            if (!m_q1[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_lvl[i] = ~m_lvl[i];
                    m_run[i] = 0;
                    if (i == 4 && m_lvl[4]) m_rose = 1;
                end
            end else m_run[i] = 0;
        end
        m_q1 = m_q0;
        m_q0 = {i_fire, i_right, i_left, i_down, i_up};
    endtask

    task automatic arm();
        k0 = k;
        n_fire = 0; n_start = 0; n_up = 0; n_down = 0; n_right = 0;
        fire_at = -1; start_at = -1; up_at = -1; down_at = -1; right_at = -1;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            if (rst) model_reset();
            else model_edge();
            @(negedge clk);
            k++;
            chk("led", o_led, e_led);
            chk("move", {o_right, o_left, o_down, o_up}, mv_bits(e_mv));
            chk("fire", o_fire, e_fire);
            chk("start", o_start, e_start);
            chk("onehot", int'($countones({o_right, o_left, o_down, o_up}) <= 1), 1);
            if (o_fire) begin n_fire++; if (fire_at < 0) fire_at = k - k0; end
            if (o_start) begin n_start++; if (start_at < 0) start_at = k - k0; end
            if (o_up) begin n_up++; if (up_at < 0) up_at = k - k0; end
            if (o_down) begin n_down++; if (down_at < 0) down_at = k - k0; end
            if (o_right) begin n_right++; if (right_at < 0) right_at = k - k0; end
        end
    endtask

    initial begin
        logic [4:0] r;
        k = 0;
        model_reset();
        arm();
        repeat (2) @(negedge clk);
        chk("rst_led", o_led, 0);
        chk("rst_pulses", {o_start, o_fire, o_right, o_left, o_down, o_up}, 0);
        chk("rst_state", int'(dut.state), int'(ST_IDLE));
        rst = 1'b0;
        step(10);
        arm();
        i_fire = 1'b0;
        step(3);
        i_fire = 1'b1;
        step(15);
        chk("glitch_fire", n_fire, 0);
        arm();
        i_fire = 1'b0;
        step(10);
        i_fire = 1'b1;
        step(15);
        chk("fire_count", n_fire, 1);
        chk("fire_latency", fire_at, 7);
        arm();
        i_right = 1'b0;
        step(60);
        i_right = 1'b1;
        step(30);
        chk("right_first", right_at, 7);
        chk("right_count", n_right, 6);
        chk("right_idle", int'(dut.state), int'(ST_IDLE));
        arm();
        i_left = 1'b0;
        step(30);
        arm();
        i_up = 1'b0;
        step(60);
        i_up = 1'b1;
        i_left = 1'b1;
        step(30);
        chk("up_first", up_at, 7);
        chk("up_count", n_up, 6);
        for (int rep = 0; rep < 2; rep++) begin
            arm();
            i_fire = 1'b0;
            step(80);
            i_fire = 1'b1;
            step(15);
            chk("hold_fire", n_fire, 1);
            chk("hold_start", n_start, 1);
            chk("start_gap", start_at - fire_at, SH - 1);
        end
        i_down = 1'b0;
        step(40);
        rst = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_out", {o_led, o_start, o_fire, o_right, o_left, o_down, o_up}, 0);
        chk("mid_rst_state", int'(dut.state), int'(ST_IDLE));
        step(3);
        rst = 1'b0;
        arm();
        step(12);
        chk("rst_down_latency", down_at, 7);
        i_down = 1'b1;
        step(20);
        repeat (60) begin
            r = 5'($urandom);
            {i_fire, i_right, i_left, i_down, i_up} = r;
            step($urandom_range(1, 40));
        end
        {i_fire, i_right, i_left, i_down, i_up} = '1;
        step(40);
        p_up = 1'b1;
        for (int j = 1; j <= 9; j++) begin
            step(1);
            chk("pol_up", q_up, int'(j == 7));
            chk("pol_led", q_led[0], int'(j >= 7));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
